alu_iterative_exec: RTL and testbench

//  Execute-stage ALU that consumes the 4-bit Operation code from the ALU controller.

---
 rtl/alu_iterative_exec.sv | 164 ++++++++++++++++
 tb/tb_alu_iterative_exec.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative_exec.sv
// Execute-stage ALU with a valid/ready operand port and a valid/ready result port.
// Logic, arithmetic and compare operations finish in one cycle. Shifts run
// iteratively, one bit position per cycle, so a single 1-bit shifter is enough.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   in_ready is high only in IDLE, so at most one operation is in flight.
//   out_valid is high only in DONE. result/zero stay stable until the edge where
//   out_ready is seen high. The unit then returns to IDLE, and out_valid drops
//   in the following cycle. No new operand is accepted in the same cycle.
module alu_iterative_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  // Operation codes driven by the ALU controller.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [SHAMT_W-1:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;

  logic [SHAMT_W-1:0]    shamt_in;
  logic                  is_shift_in;
  logic [DATA_WIDTH-1:0] single_res;
  logic [DATA_WIDTH-1:0] shift_step;

  // Only the low shamt bits of src_b matter for shifts; the rest are ignored.
  assign shamt_in    = src_b[SHAMT_W-1:0];
  assign is_shift_in = (operation == OP_SLL) || (operation == OP_SRL) ||
                       (operation == OP_SRA);

  // One-cycle result. A shift by zero is src_a unchanged. Undefined codes give 0.
  always_comb begin
    single_res = '0;
    case (operation)
      OP_ADD: single_res = src_a + src_b;
      OP_SUB: single_res = src_a - src_b;
      OP_AND: single_res = src_a & src_b;
      OP_OR:  single_res = src_a | src_b;
      OP_XOR: single_res = src_a ^ src_b;
      OP_SLL: single_res = src_a;
      OP_SRL: single_res = src_a;
      OP_SRA: single_res = src_a;
      OP_BEQ: single_res = {{(DATA_WIDTH-1){1'b0}}, (src_a == src_b)};
      OP_SLT: single_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: single_res = '0;
    endcase
  end

  // Single-bit shifter applied to the working register once per SHIFT cycle.
  always_comb begin
    shift_step = work_q;
    case (op_q)
      OP_SLL: shift_step = {work_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL: shift_step = {1'b0, work_q[DATA_WIDTH-1:1]};
      OP_SRA: shift_step = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
      default: shift_step = work_q;
    endcase
  end

  // Next-state and datapath-update logic for the IDLE/SHIFT/DONE controller.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    count_d  = count_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = operation;
          if (is_shift_in && (shamt_in != '0)) begin
            work_d  = src_a;
            count_d = shamt_in;
            state_d = SHIFT;
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        work_d  = shift_step;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          result_d = shift_step;
          zero_d   = (shift_step == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any operation immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      work_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Bench for alu_iterative_exec: directed corner cases, then randomized
// back-to-back operations with random output backpressure, all scored against
// a plain-arithmetic reference model.
module tb_alu_iterative_exec;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   operation;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  alu_iterative_exec #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operation  (operation),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_z_q[$];
  int           exp_lat_q[$];
  int           exp_c0_q[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int sh;
    sh = int'(b % W);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return W'($signed(a) >>> sh);
      4'd8: return (a == b) ? W'(1) : W'(0);
      4'd9: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
    if (op == 4'd5 || op == 4'd6 || op == 4'd7) return 1 + int'(b % W);
    return 1;
  endfunction

  // ---------------- output backpressure driver ----------------
  bit hold_ready = 1'b0;
  bit rand_bp    = 1'b0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_ready)   out_ready = 1'b0;
      else if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      else              out_ready = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  // Scores every result when out_valid rises; latency is measured from the
  // cycle in which the operand handshake completed.
  initial begin
    logic prev_v;
    logic [W-1:0] er;
    logic ez;
    int el;
    int ec;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_output: got result 0x%08h, expected no output", result);
          end else begin
            er = exp_q.pop_front();
            ez = exp_z_q.pop_front();
            el = exp_lat_q.pop_front();
            ec = exp_c0_q.pop_front();
            check("result", result, er);
            check("zero", W'(zero), W'(ez));
            check("latency", W'(cyc - ec), W'(el));
          end
        end
        prev_v = out_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [W-1:0] r;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready=0, expected 1 within 200 cycles");
      return;
    end
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    r = ref_alu(op, a, b);
    exp_q.push_back(r);
    exp_z_q.push_back(r == '0);
    exp_lat_q.push_back(ref_lat(op, b));
    exp_c0_q.push_back(cyc);
    @(negedge clk);
    in_valid  = 1'b0;
    operation = 4'($urandom_range(0, 15));
    src_a     = $urandom;
    src_b     = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", W'(exp_q.size()), W'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, W'(out_valid), W'(0));
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    check({tag, "_busy"}, W'(busy), W'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] xr;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int n;

    reset     = 1'b1;
    in_valid  = 1'b0;
    operation = '0;
    src_a     = '0;
    src_b     = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_result", result, '0);
    check("reset_zero", W'(zero), W'(0));
    reset = 1'b0;
    @(negedge clk);

    // Wraparound add, subtract, signed compare, equality.
    issue(4'd0, 32'hFFFF_FFFF, 32'h1);
    issue(4'd1, 32'd5, 32'd7);
    issue(4'd9, 32'hFFFF_FFFF, 32'h1);
    issue(4'd8, 32'h1234, 32'h1234);
    issue(4'd9, 32'h7FFF_FFFF, 32'h8000_0000);
    // Shifts: arithmetic fill, maximum amount, zero amount with upper bits set.
    issue(4'd7, 32'h8000_0000, 32'd4);
    issue(4'd5, 32'h1, 32'd31);
    issue(4'd6, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
    issue(4'd6, 32'h8000_0000, 32'h0000_0121);
    // Undefined operation codes.
    issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Result held stable under backpressure, then release.
    hold_ready = 1'b1;
    @(negedge clk);
    xr = ref_alu(4'd4, 32'hA5A5_F00F, 32'h0FF0_FFFF);
    issue(4'd4, 32'hA5A5_F00F, 32'h0FF0_FFFF);
    repeat (10) begin
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_result", result, xr);
      check("bp_in_ready", W'(in_ready), W'(0));
      @(negedge clk);
    end
    hold_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("bp_release");

    // Reset in the middle of a long shift.
    issue(4'd5, $urandom, 32'd20);
    repeat (7) @(negedge clk);
    check("mid_shift_busy", W'(busy), W'(1));
    reset = 1'b1;
    exp_q.delete();
    exp_z_q.delete();
    exp_lat_q.delete();
    exp_c0_q.delete();
    @(negedge clk);
    check_idle_outputs("in_reset");
    check("in_reset_result", result, '0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("post_reset");
    end
    check("post_reset_result", result, '0);

    // Randomized back-to-back operations with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      n  = int'($urandom_range(0, 7));
      if (n == 0) b = a;
      if (n == 1) b = b & 32'h1F;
      if (n == 2) a = 32'h8000_0000 | a;
      issue(op, a, b);
    end
    drain();
    rand_bp = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
